// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode IR, run the execute steps, each held STEP_CYCLES clocks.
// Optional trap on undefined opcodes under `CTRL_ILLEGAL_TRAP_EN.
module control_sequencer #(
    parameter int unsigned STEP_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Clear_n,
    input  logic [31:0] IR,
    input  logic        Start,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        illegal_op
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_U3, S_U4, S_HALT
    } state_t;

    typedef struct packed {
        logic        pcout;
        logic        pcin;
        logic        incpc;
        logic        marin;
        logic        read;
        logic        mdrin;
        logic        mdrout;
        logic        irin;
        logic        yin;
        logic        zin;
        logic        zlowout;
        logic        zhighout;
        logic        hiin;
        logic        loin;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             adv_c;

    logic [4:0] op_c;
    logic [3:0] ra_c, rb_c, rc_c;
    logic       is_alu_c, is_muldiv_c, is_unary_c, is_nop_c, is_halt_c;
    logic       unused_ir_c;

    assign op_c        = IR[31:27];
    assign ra_c        = IR[26:23];
    assign rb_c        = IR[22:19];
    assign rc_c        = IR[18:15];
    assign unused_ir_c = ^IR[14:0];

    assign is_alu_c    = (op_c >= 5'd3) && (op_c <= 5'd10);
    assign is_muldiv_c = (op_c == 5'd15) || (op_c == 5'd16);
    assign is_unary_c  = (op_c == 5'd17) || (op_c == 5'd18);
    assign is_nop_c    = (op_c == 5'd26);
    assign is_halt_c   = (op_c == 5'd27);

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
`endif

    // Next state and step counter; state only moves when the step counter wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv_c   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d = S_T0;
                    adv_c   = 1'b1;
                end
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    adv_c = 1'b1;
                    case (state_q)
                        S_T0: state_d = S_T1;
                        S_T1: state_d = S_T2;
                        S_T2: begin
                            if (is_alu_c || is_muldiv_c) state_d = S_T3;
                            else if (is_unary_c)         state_d = S_U3;
                            else if (is_halt_c)          state_d = S_HALT;
                            else if (is_nop_c)           state_d = Stop ? S_IDLE : S_T0;
                            else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                                state_d = S_HALT;
                                ill_d   = 1'b1;
`else
                                state_d = Stop ? S_IDLE : S_T0;
`endif
                            end
                        end
                        S_T3: state_d = S_T4;
                        S_T4: state_d = S_T5;
                        S_T5: state_d = is_muldiv_c ? S_T6 : (Stop ? S_IDLE : S_T0);
                        S_T6: state_d = Stop ? S_IDLE : S_T0;
                        S_U3: state_d = S_U4;
                        S_U4: state_d = Stop ? S_IDLE : S_T0;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Strobes for the state being entered; latched only on a step transition.
    always_comb begin
        ctrl_d     = '0;
        ctrl_d.run = (state_d != S_IDLE) && (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                ctrl_d.pcout = 1'b1;
                ctrl_d.marin = 1'b1;
                ctrl_d.incpc = 1'b1;
                ctrl_d.pcin  = 1'b1;
            end
            S_T1: begin
                ctrl_d.read  = 1'b1;
                ctrl_d.mdrin = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdrout = 1'b1;
                ctrl_d.irin   = 1'b1;
            end
            S_T3: begin
                ctrl_d.rout = onehot(rb_c);
                ctrl_d.yin  = 1'b1;
            end
            S_T4: begin
                ctrl_d.rout = onehot(rc_c);
                ctrl_d.zin  = 1'b1;
                ctrl_d.alu  = op_c - 5'd2;
            end
            S_T5: begin
                ctrl_d.zlowout = 1'b1;
                if (is_muldiv_c) ctrl_d.loin = 1'b1;
                else             ctrl_d.rin  = onehot(ra_c);
            end
            S_T6: begin
                ctrl_d.zhighout = 1'b1;
                ctrl_d.hiin     = 1'b1;
            end
            S_U3: begin
                ctrl_d.rout = onehot(rb_c);
                ctrl_d.zin  = 1'b1;
                ctrl_d.alu  = op_c - 5'd2;
            end
            S_U4: begin
                ctrl_d.zlowout = 1'b1;
                ctrl_d.rin     = onehot(ra_c);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (adv_c) ctrl_q <= ctrl_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) ill_q <= 1'b0;
        else          ill_q <= ill_d;
    end
    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign PCout    = ctrl_q.pcout;
    assign PCin     = ctrl_q.pcin;
    assign IncPC    = ctrl_q.incpc;
    assign MARin    = ctrl_q.marin;
    assign Read     = ctrl_q.read;
    assign MDRin    = ctrl_q.mdrin;
    assign MDRout   = ctrl_q.mdrout;
    assign IRin     = ctrl_q.irin;
    assign Yin      = ctrl_q.yin;
    assign Zin      = ctrl_q.zin;
    assign Zlowout  = ctrl_q.zlowout;
    assign Zhighout = ctrl_q.zhighout;
    assign HIin     = ctrl_q.hiin;
    assign LOin     = ctrl_q.loin;
    assign Rin      = ctrl_q.rin;
    assign Rout     = ctrl_q.rout;
    assign alu_op   = ctrl_q.alu;
    assign Run      = ctrl_q.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-clock strobe vectors are queued, then compared at each negedge.
module tb_control_sequencer;

    localparam int STEP = 2;

    logic        Clock, Clear_n, Start, Stop;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Run, illegal_op;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;

    control_sequencer #(.STEP_CYCLES(STEP)) dut (
        .Clock(Clock), .Clear_n(Clear_n), .IR(IR), .Start(Start), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic        pcout, pcin, incpc, marin, read, mdrin, mdrout, irin;
        logic        yin, zin, zlowout, zhighout, hiin, loin;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_ill  = 1'b0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic exp_t sample();
        exp_t s;
        s.pcout = PCout;  s.pcin = PCin;   s.incpc = IncPC;     s.marin = MARin;
        s.read = Read;    s.mdrin = MDRin; s.mdrout = MDRout;   s.irin = IRin;
        s.yin = Yin;      s.zin = Zin;     s.zlowout = Zlowout; s.zhighout = Zhighout;
        s.hiin = HIin;    s.loin = LOin;   s.rin = Rin;         s.rout = Rout;
        s.alu = alu_op;   s.run = Run;     s.ill = illegal_op;
        return s;
    endfunction

    function automatic exp_t e_base(input logic run);
        exp_t e = '0;
        e.run = run;
        e.ill = exp_ill;
        return e;
    endfunction

    task automatic push_step(input exp_t e);
        repeat (STEP) sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        repeat (n) sb.push_back(e_base(1'b0));
    endtask

    task automatic push_fetch();
        exp_t e;
        e = e_base(1'b1); e.pcout = 1; e.marin = 1; e.incpc = 1; e.pcin = 1; push_step(e);
        e = e_base(1'b1); e.read = 1; e.mdrin = 1;                            push_step(e);
        e = e_base(1'b1); e.mdrout = 1; e.irin = 1;                           push_step(e);
    endtask

    task automatic drain(input string tag, input int stop_at, input int start_at);
        exp_t e, a;
        int   idx = 0;
        while (sb.size() > 0 && idx < 400) begin
            Stop  = (idx >= stop_at);
            Start = (idx == start_at);
            @(negedge Clock);
            e = sb.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s clk%0d: got %h expected %h", tag, idx, a, e);
            end
            idx++;
        end
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] ir, input int stop_at, input int start_at);
        IR    = ir;
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        drain(tag, stop_at, start_at);
    endtask

    task automatic test_reset();
        exp_t a;
        Clear_n = 1'b0; Start = 1'b0; Stop = 1'b0; IR = '0;
        #12;
        a = sample();
        checks++;
        if (a !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_hold: got %h expected 0", a);
        end
        @(negedge Clock);
        Clear_n = 1'b1;
        push_idle(3);
        drain("reset_idle", 0, -1);
    endtask

    task automatic test_alu();
        exp_t e;
        push_fetch();
        e = e_base(1'b1); e.rout = 16'h0004; e.yin = 1;                  push_step(e);
        e = e_base(1'b1); e.rout = 16'h0008; e.zin = 1; e.alu = 5'b00011; push_step(e);
        e = e_base(1'b1); e.rin = 16'h0002; e.zlowout = 1;               push_step(e);
        push_idle(2);
        run("alu_and", 32'h2891_8000, 0, -1);
    endtask

    task automatic test_muldiv();
        exp_t e;
        push_fetch();
        e = e_base(1'b1); e.rout = 16'h0010; e.yin = 1;                  push_step(e);
        e = e_base(1'b1); e.rout = 16'h0020; e.zin = 1; e.alu = 5'b01101; push_step(e);
        e = e_base(1'b1); e.zlowout = 1; e.loin = 1;                     push_step(e);
        e = e_base(1'b1); e.zhighout = 1; e.hiin = 1;                    push_step(e);
        push_idle(2);
        run("mul", {5'b01111, 4'd1, 4'd4, 4'd5, 15'd0}, 0, -1);
    endtask

    task automatic test_unary();
        exp_t e;
        push_fetch();
        e = e_base(1'b1); e.rout = 16'h0040; e.zin = 1; e.alu = 5'b10000; push_step(e);
        e = e_base(1'b1); e.rin = 16'h0080; e.zlowout = 1;               push_step(e);
        push_idle(2);
        run("not", {5'b10010, 4'd7, 4'd6, 4'd0, 15'd0}, 0, -1);
    endtask

    // Two nops back to back; a Start pulse mid-fetch must be ignored, Stop only honoured at the second boundary.
    task automatic test_back_to_back();
        push_fetch();
        push_fetch();
        push_idle(2);
        run("nop_b2b", {5'b11010, 27'd0}, 4 * STEP + 2 * STEP, 3);
    endtask

    task automatic test_halt();
        push_fetch();
        push_idle(4);
        run("halt", {5'b11011, 27'd0}, 1000, -1);
        push_fetch();
        push_idle(2);
        run("halt_restart", {5'b11010, 27'd0}, 0, -1);
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        push_fetch();
        exp_ill = 1'b1;
        push_idle(3);
        run("illegal_trap", {5'b11111, 27'd0}, 1000, -1);
        push_fetch();
        push_idle(2);
        run("illegal_sticky", {5'b11010, 27'd0}, 0, -1);
`else
        push_fetch();
        push_fetch();
        push_idle(2);
        run("illegal_as_nop", {5'b11111, 27'd0}, 3 * STEP * 2, -1);
`endif
    endtask

    // Reset during T4 must clear every strobe immediately, without a clock edge.
    task automatic test_reset_mid_step();
        exp_t a;
        IR    = 32'h2891_8000;
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (4 * STEP) @(posedge Clock);
        #2;
        checks++;
        if (Rout !== 16'h0008 || Zin !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_T4: got Rout=%h Zin=%b expected Rout=0008 Zin=1", Rout, Zin);
        end
        Clear_n = 1'b0;
        #1;
        a = sample();
        checks++;
        if (a !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_mid_T4: got %h expected 0", a);
        end
        @(negedge Clock);
        Clear_n = 1'b1;
        exp_ill = 1'b0;
        push_idle(3);
        drain("post_reset_idle", 0, -1);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_unary();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's strobes in place of a bench-driven state machine.
- Fetches each instruction (T0-T2), decodes IR, and runs the register-register ALU, mul/div, neg/not, nop and halt execute steps (T3-T6), one control step per STEP_CYCLES clocks.
- Sits beside the datapath. Outputs connect 1:1 to the datapath's control inputs; register enables are one-hot 16-bit vectors {R15..R0}.

Parameters:
- STEP_CYCLES, 2, clocks each control step is held (>=1); all step outputs stay asserted for the whole step.

Ports:
- Clock  in  1  system clock, rising edge
- Clear_n  in  1  asynchronous active-low reset
- IR  in  32  instruction register contents from datapath
- Start  in  1  pulse; leaves IDLE/HALT and begins fetch
- Stop  in  1  level; sampled at instruction boundary
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes
- Rin  out  16  one-hot register write enable
- Rout  out  16  one-hot register bus drive
- alu_op  out  5  ALU operation code
- Run  out  1  high while sequencing
- illegal_op  out  1  sticky flag (see Optional Feature)

Behaviour:
- Reset (Clear_n=0, async): state IDLE, step counter 0, all outputs 0, Run=0, illegal_op=0. Reset mid-step aborts immediately with no partial strobes.
- IR fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]. Rin/Rout are the one-hot decode of the selected field.
- alu_op = op - 5'd2 (mod 32) during Zin steps, else 0. Example: and (op 00101) gives alu_op 00011.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
- States and asserted outputs; Moore, registered, constant through each step:
  - IDLE: none. Start goes to T0.
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
  - Branch after T2 on op:
    - ALU class (00011-01010, 01111, 10000) goes to T3.
    - neg/not goes to U3.
    - nop goes to the boundary.
    - halt goes to HALT.
  - T3: Rout=Rb, Yin.
  - T4: Rout=Rc, Zin, alu_op.
  - T5, ALU class: Zlowout, Rin=Ra; then boundary.
  - T5, mul/div: Zlowout, LOin; then T6.
  - T6: Zhighout, HIin; then boundary.
  - U3: Rout=Rb, Zin, alu_op.
  - U4: Zlowout, Rin=Ra; then boundary.
  - HALT: none, Run=0. Start goes to T0.
- Boundary: on the final clock of the last step, Stop=1 goes to IDLE, else T0.
- Step counter counts 0..STEP_CYCLES-1 and the state advances when it wraps.
- Outputs change only on state change, so no glitch between consecutive steps with identical strobes.
- Run=1 in every state except IDLE/HALT.
- Start is ignored while Run=1. Start and Stop together at a boundary: Stop wins.
- Undefined opcode: handled per Optional Feature.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode after T2 goes to HALT and sets illegal_op=1. illegal_op is sticky until Clear_n.
- Undefined: an undefined opcode is treated as nop, and illegal_op is tied to 0.

Test Plan:
- Reset asserted mid-T4 (Rout=0x0008, Zin=1) -> all outputs 0 same instant, state IDLE, Run=0.
- STEP_CYCLES=2, Start, IR=0x28918000 -> T0..T5 each 2 clocks (12 clocks). T3 Rout=0x0004; T4 Rout=0x0008, alu_op=00011; T5 Rin=0x0002, Zlowout.
- IR mul (op 01111, Rb=R4, Rc=R5) -> T5 LOin+Zlowout, T6 HIin+Zhighout, Rin=0 throughout.
- IR not (op 10010, Ra=R7, Rb=R6) -> U3 Rout=0x0040, alu_op=10000; U4 Rin=0x0080.
- Stop=1 during nop, then halt -> IDLE after nop T2. Later Start with IR=halt -> HALT after T2, Run=0; Start restarts at T0.
- IR op 11111 -> with CTRL_ILLEGAL_TRAP_EN: HALT, illegal_op=1. Without it: straight to T0, illegal_op=0.
